// File: rtl/rvbridge_pix_fifo_pkg.sv
// Bridge-wide constants shared by the raw-to-VIP bridge blocks.
// Holds the default pixel/fill-count widths and the FIFO capacity helper.
package rvbridge_pix_fifo_pkg;

  localparam int unsigned PIX_DATA_WIDTH  = 24;
  localparam int unsigned PIX_USEDW_WIDTH = 15;

  // Capacity is one short of the power of two so the fill count never wraps.
  function automatic int unsigned fifo_depth(input int unsigned usedw_width);
    return (32'd1 << usedw_width) - 32'd1;
  endfunction

endpackage

// File: rtl/rvbridge_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Reading the address being written in the same cycle returns the new word.
module rvbridge_sdp_ram #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned WORDS = 32'd1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Forwarding covers the empty-FIFO case, where the prefetch reads the slot being written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rvbridge_pix_fifo.sv
// Show-ahead pixel FIFO between the sensor capture logic and the VIP packetiser.
// RAM read register feeds a one-word output register; usedw counts every stage.
module rvbridge_pix_fifo
  import rvbridge_pix_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = PIX_DATA_WIDTH,
  parameter int unsigned USEDW_WIDTH = PIX_USEDW_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sclr,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [USEDW_WIDTH-1:0] usedw,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam logic [USEDW_WIDTH-1:0] DEPTH     = USEDW_WIDTH'(fifo_depth(USEDW_WIDTH));
  localparam logic [USEDW_WIDTH-1:0] LAST_ADDR = DEPTH - USEDW_WIDTH'(1);

  function automatic logic [USEDW_WIDTH-1:0] ptr_next(input logic [USEDW_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + USEDW_WIDTH'(1);
  endfunction

  logic [USEDW_WIDTH-1:0] wptr_q, wptr_d;
  logic [USEDW_WIDTH-1:0] rptr_q, rptr_d;
  logic [USEDW_WIDTH-1:0] ramcnt_q, ramcnt_d;
  logic [USEDW_WIDTH-1:0] usedw_q, usedw_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   s1_q, s1_d;
  logic                   ov_q, ov_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                   ovf_q, ovf_d;

  logic                   wr_acc;
  logic                   pop;
  logic                   out_load;
  logic                   ram_rd;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  // s1_q marks a valid word in the RAM read register; ov_q marks the output register.
  assign wr_acc   = wr_en && !full_q && !sclr;
  assign pop      = ov_q && rd_ready;
  assign out_load = s1_q && (!ov_q || pop);
  assign ram_rd   = ((ramcnt_q != '0) || wr_acc) && (!s1_q || out_load) && !sclr;

  rvbridge_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(USEDW_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_acc),
    .waddr_i(wptr_q),
    .wdata_i(wr_data),
    .re_i   (ram_rd),
    .raddr_i(rptr_q),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    ramcnt_d = ramcnt_q;
    usedw_d  = usedw_q;
    s1_d     = s1_q;
    ov_d     = ov_q;
    dout_d   = dout_q;
    ovf_d    = (wr_en && full_q) || (ovf_q && !clr_ovf);

    if (sclr) begin
      wptr_d   = '0;
      rptr_d   = '0;
      ramcnt_d = '0;
      usedw_d  = '0;
      s1_d     = 1'b0;
      ov_d     = 1'b0;
      dout_d   = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = ptr_next(wptr_q);
      end
      if (ram_rd) begin
        rptr_d = ptr_next(rptr_q);
      end

      case ({wr_acc, ram_rd})
        2'b10:   ramcnt_d = ramcnt_q + USEDW_WIDTH'(1);
        2'b01:   ramcnt_d = ramcnt_q - USEDW_WIDTH'(1);
        default: ramcnt_d = ramcnt_q;
      endcase

      case ({wr_acc, pop})
        2'b10:   usedw_d = usedw_q + USEDW_WIDTH'(1);
        2'b01:   usedw_d = usedw_q - USEDW_WIDTH'(1);
        default: usedw_d = usedw_q;
      endcase

      if (ram_rd) begin
        s1_d = 1'b1;
      end else if (out_load) begin
        s1_d = 1'b0;
      end

      if (out_load) begin
        ov_d   = 1'b1;
        dout_d = ram_rdata;
      end else if (pop) begin
        ov_d = 1'b0;
      end
    end

    full_d  = (usedw_d == DEPTH);
    empty_d = (usedw_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      ramcnt_q <= '0;
      usedw_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      s1_q     <= 1'b0;
      ov_q     <= 1'b0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ramcnt_q <= ramcnt_d;
      usedw_q  <= usedw_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      s1_q     <= s1_d;
      ov_q     <= ov_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rd_valid = ov_q;
  assign rd_data  = dout_q;
  assign usedw    = usedw_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rvbridge_pix_fifo.sv
// Scoreboard bench for rvbridge_pix_fifo with a 15-word instance (USEDW_WIDTH = 4).
// Accepted writes are queued; the read monitor checks head data and the fill-count model.
module tb_rvbridge_pix_fifo;

  localparam int DW    = 24;
  localparam int UW    = 4;
  localparam int DEPTH = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [UW-1:0] usedw;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] exp_q[$];
  int            mcnt = 0;
  logic          movf = 1'b0;

  rvbridge_pix_fifo #(
    .DATA_WIDTH (DW),
    .USEDW_WIDTH(UW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sclr    (sclr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .usedw   (usedw),
    .full    (full),
    .empty   (empty),
    .overflow(overflow),
    .clr_ovf (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected-stream model: decides acceptance and tracks count/overflow from the inputs alone.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("usedw", 32'(usedw), 32'(mcnt));
      chk("full", 32'(full), 32'(mcnt == DEPTH));
      chk("empty", 32'(empty), 32'(mcnt == 0));
      chk("overflow", 32'(overflow), 32'(movf));
    end
    if (!rst_n) begin
      mcnt = 0;
      movf = 1'b0;
    end else begin
      logic acc, rd;
      acc  = wr_en && (mcnt != DEPTH) && !sclr;
      rd   = rd_valid && rd_ready;
      movf = (wr_en && (mcnt == DEPTH)) || (movf && !clr_ovf);
      if (acc) exp_q.push_back(wr_data);
      if (sclr) mcnt = 0;
      else      mcnt = mcnt + int'(acc) - int'(rd);
    end
  end

  // Read monitor: the presented word must be the oldest expected one.
  always @(negedge clk) begin
    if (chk_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got rd_data=%0h want no word", rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
        if (rd_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
    if (!rst_n || sclr) exp_q.delete();
  end

  task automatic drain(input string nm);
    int unsigned n;
    n = 0;
    wr_en    = 1'b0;
    rd_ready = 1'b1;
    while (!empty && n < 64) begin
      step();
      n++;
    end
    if (!empty) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got usedw=%0d want 0 within 64 cycles", nm, usedw);
    end
    rd_ready = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_empty", 32'(empty), 1);
    rst_n = 1'b1;
    step();

    // Single word fall-through and hold
    wr_en = 1'b1; wr_data = 24'h123456;
    step();
    wr_en = 1'b0;
    chk("single_usedw", 32'(usedw), 1);
    chk("single_valid_early", 32'(rd_valid), 0);
    step();
    chk("single_valid", 32'(rd_valid), 1);
    chk("single_data", 32'(rd_data), 32'h123456);
    step();
    step();
    chk("single_hold", 32'(rd_data), 32'h123456);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("single_usedw_after", 32'(usedw), 0);
    chk("single_empty_after", 32'(empty), 1);
    chk("single_valid_after", 32'(rd_valid), 0);

    // Fill to full, drop the 16th word, drain in order
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 24'(i);
      step();
      if (i == 14) begin
        chk("fill_full", 32'(full), 1);
        chk("fill_usedw", 32'(usedw), 15);
        chk("fill_ovf_before", 32'(overflow), 0);
      end
    end
    wr_en = 1'b0;
    chk("fill_ovf_after", 32'(overflow), 1);
    chk("fill_usedw_after_drop", 32'(usedw), 15);
    p0 = n_pop;
    drain("fill_drain");
    chk("fill_drain_count", 32'(n_pop - p0), 15);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      wr_data  = 24'($urandom);
      step();
    end
    drain("rand_drain");
    chk("rand_queue_empty", 32'(exp_q.size()), 0);

    // Write while full with a completing read and a simultaneous clear
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 24'hA000 + 24'(i);
      step();
    end
    wr_en = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("wf_full", 32'(full), 1);
    chk("wf_ovf_cleared", 32'(overflow), 0);
    wr_en = 1'b1; wr_data = 24'hBEEF; rd_ready = 1'b1; clr_ovf = 1'b1;
    step();
    wr_en = 1'b0; clr_ovf = 1'b0;
    chk("wf_usedw", 32'(usedw), 14);
    chk("wf_ovf_set", 32'(overflow), 1);
    for (int i = 0; i < 7; i++) step();
    rd_ready = 1'b0;
    chk("wf_usedw7", 32'(usedw), 7);

    // Flush keeps overflow and discards the write in the same cycle
    sclr = 1'b1; wr_en = 1'b1; wr_data = 24'hDEAD;
    step();
    sclr = 1'b0; wr_en = 1'b0;
    chk("sclr_usedw", 32'(usedw), 0);
    chk("sclr_valid", 32'(rd_valid), 0);
    chk("sclr_ovf_kept", 32'(overflow), 1);
    step();
    chk("sclr_write_gone", 32'(rd_valid), 0);

    // Streaming at one word per cycle
    wr_en = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wr_data = 24'h400000 + 24'(i);
      step();
      if (i >= 2) begin
        chk("stream_valid", 32'(rd_valid), 1);
        chk("stream_usedw", 32'(usedw), 2);
      end
    end

    // Reset mid-stream
    rst_n = 1'b0;
    step();
    chk("mrst_valid", 32'(rd_valid), 0);
    chk("mrst_data", 32'(rd_data), 0);
    chk("mrst_usedw", 32'(usedw), 0);
    chk("mrst_full", 32'(full), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_ovf", 32'(overflow), 0);
    rst_n = 1'b1; wr_en = 1'b0; rd_ready = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
